adding_machine_sequencer: RTL and testbench
===========================================

// Module: adding_machine_sequencer
// PURPOSE
//  Run controller for the adding-machine datapath: sums LENGTH consecutive ROM words from BASE.
//  Drives the ROM word index and owns one pipeline register (ROM data -> adder) plus the accumulator.
//  Sequences fill, run and drain per job, honours a global hold, and flags completion with a one-cycle done.
// PARAMETERS
//  LEN_W   16   width of the length field / remaining-word counter
//  SUM_W   32   accumulator and ROM data width
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  start      in   1      job request; sampled only in IDLE
//  base       in   30     first ROM word index, word address bits [31:2]
//  length     in   LEN_W  number of words to sum
//  hold       in   1      freeze all state while high
//  rom_data   in   SUM_W  ROM word for rom_index, combinational
//  rom_index  out  30     current ROM word index
//  busy       out  1      high in FETCH and DRAIN
//  done       out  1      one-cycle completion pulse (DONE state)
//  sum        out  SUM_W  accumulator; held after DONE until the next accepted start
// BEHAVIOUR
//  Reset (async): state=IDLE, rom_index=0, sum=0, stage_valid=0, remaining=0, busy=0, done=0.
//  States: IDLE, FETCH, DRAIN, DONE. All transitions are gated by !hold.
//  IDLE:
//   - start & length!=0 -> FETCH; latch rom_index=base, remaining=length; sum<=0.
//   - start & length==0 -> DONE; sum<=0.
//  FETCH:
//   - Each cycle: stage<=rom_data, stage_valid<=1, rom_index<=rom_index+1, remaining<=remaining-1.
//   - remaining==1 -> DRAIN.
//  Accumulate: in any state, stage_valid & !hold -> sum<=sum+stage (mod 2^SUM_W).
//  DRAIN: accumulates the last staged word; stage_valid<=0 -> DONE.
//  DONE: done=1 for exactly one cycle -> IDLE. sum is final in this cycle.
//  Latency: start sampled at edge E0, N=length>0, no hold:
//   - rom_index=base+k in cycles 1..N; done high in cycle N+2.
//  hold=1: state, rom_index, stage, stage_valid, remaining and sum are all frozen.
//   - done stays high across hold cycles in DONE; start is ignored while held.
//  start outside IDLE is ignored (no queueing). base/length are only read at acceptance.
//  rom_index wraps modulo 2^30 (3FFFFFFF+1 -> 0); no error.
//  Reset asserted mid-job aborts immediately to reset values; no done pulse is emitted.
//  start in the same cycle as DONE is ignored (DONE is not IDLE).
// CONFIGURATION
//  ADDING_SEQ_OVERFLOW_EN defined:
//   - Adds output `overflow` (1 bit), reset 0, cleared on accepted start.
//   - Set sticky when any accumulate produces a signed two's-complement overflow.
//   - Valid alongside done.
//  ADDING_SEQ_OVERFLOW_EN undefined:
//   - No overflow port or logic; sum wraps silently modulo 2^SUM_W.
// TESTING
//  1 ROM[0..3]=1,2,3,4; start base=0 len=4 -> rom_index 0,1,2,3 in cycles 1-4; done cycle 6; sum=10.
//  2 start len=0 -> done in cycle 1, sum=0, busy never high, rom_index unchanged.
//  3 As test 1 with hold=1 for 3 cycles at cycle 2 -> done in cycle 9; sum=10; rom_index frozen during hold.
//  4 base=30'h3FFFFFFE len=3, ROM 5,6,7 -> indices 3FFFFFFE, 3FFFFFFF, 0; sum=18.
//  5 Drop reset in cycle 3 of a len=4 job -> all outputs 0 at once; no done.
//    New start after release -> fresh correct sum.
//  6 ADDING_SEQ_OVERFLOW_EN: ROM 32'h7FFFFFFF, 1; len=2 -> sum=32'h80000000, overflow=1 at done.
//    Next start clears overflow.
//    Without the macro: same sum, no port.

Source files
------------

// File: rtl/adding_machine_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adding_machine_sequencer
//  Description : Run controller for the adding-machine datapath. It sums
//                LENGTH consecutive ROM words starting at word index BASE.
//                It drives the ROM word index, owns one pipeline stage
//                (ROM data -> adder) and the accumulator, and sequences the
//                fill, run and drain phases of each job. A global hold
//                freezes all state. Completion is flagged by a one-cycle done.
//  Options     : ADDING_SEQ_OVERFLOW_EN adds a sticky signed-overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module adding_machine_sequencer #(
    parameter int LEN_W = 16,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [29:0]      base,
    input  logic [LEN_W-1:0] length,
    input  logic             hold,
    input  logic [SUM_W-1:0] rom_data,
    output logic [29:0]      rom_index,
    output logic             busy,
    output logic             done,
`ifdef ADDING_SEQ_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [SUM_W-1:0] sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [29:0]        r_index;
    logic [SUM_W-1:0]   r_stage;
    logic               r_stage_valid;
    logic [LEN_W-1:0]   r_remaining;
    logic [SUM_W-1:0]   r_sum;
    logic               r_busy;
    logic               r_done;
    logic [SUM_W-1:0]   w_sum_next;

    assign w_sum_next = r_sum + r_stage;

`ifdef ADDING_SEQ_OVERFLOW_EN
    logic               r_overflow;
    logic               w_add_ovf;

    // Signed overflow: operands agree in sign but the result does not.
    assign w_add_ovf = (r_sum[SUM_W-1] == r_stage[SUM_W-1]) &&
                       (w_sum_next[SUM_W-1] != r_sum[SUM_W-1]);
    assign overflow  = r_overflow;
`endif

    assign rom_index = r_index;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;

    // Job sequencer, fetch pipeline and accumulator; everything frozen by hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_index       <= 30'd0;
            r_stage       <= '0;
            r_stage_valid <= 1'b0;
            r_remaining   <= '0;
            r_sum         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
`ifdef ADDING_SEQ_OVERFLOW_EN
            r_overflow    <= 1'b0;
`endif
        end else if (!hold) begin
            // The staged word is added whatever the state; the pipeline
            // simply runs one cycle behind the fetch.
            if (r_stage_valid) begin
                r_sum <= w_sum_next;
`ifdef ADDING_SEQ_OVERFLOW_EN
                if (w_add_ovf) begin
                    r_overflow <= 1'b1;
                end
`endif
            end

            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_sum <= '0;
`ifdef ADDING_SEQ_OVERFLOW_EN
                        r_overflow <= 1'b0;
`endif
                        if (length != '0) begin
                            r_state     <= FETCH;
                            r_index     <= base;
                            r_remaining <= length;
                            r_busy      <= 1'b1;
                        end else begin
                            // Empty job completes immediately, index untouched.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    r_stage       <= rom_data;
                    r_stage_valid <= 1'b1;
                    r_index       <= r_index + 30'd1;
                    r_remaining   <= r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        r_state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Last staged word is being accumulated this cycle.
                    r_stage_valid <= 1'b0;
                    r_state       <= DONE;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                end

                DONE: begin
                    // start is deliberately not sampled here.
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adding_machine_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adding_machine_sequencer
//  Description : Self-checking bench for adding_machine_sequencer. A small
//                ROM model feeds the DUT; each job's expected per-cycle
//                timeline and final sum are derived from the job description.
//  Options     : ADDING_SEQ_OVERFLOW_EN also checks the overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adding_machine_sequencer;

    localparam int LEN_W = 16;
    localparam int SUM_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [29:0]      base = 30'd0;
    logic [LEN_W-1:0] length = '0;
    logic             hold = 1'b0;
    logic [SUM_W-1:0] rom_data;
    logic [29:0]      rom_index;
    logic             busy;
    logic             done;
    logic [SUM_W-1:0] sum;
`ifdef ADDING_SEQ_OVERFLOW_EN
    logic             overflow;
`endif

    logic [SUM_W-1:0] mem [16];
    logic [29:0]      last_index = 30'd0;
    int               n_cmp = 0;
    int               n_fail = 0;

    typedef struct {
        logic [29:0] idx;
        logic        b;
        logic        d;
    } cyc_t;

    assign rom_data = mem[rom_index[3:0]];

    always #5 clk = ~clk;

    adding_machine_sequencer #(
        .LEN_W (LEN_W),
        .SUM_W (SUM_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .length    (length),
        .hold      (hold),
        .rom_data  (rom_data),
        .rom_index (rom_index),
        .busy      (busy),
        .done      (done),
`ifdef ADDING_SEQ_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .sum       (sum)
    );

    function automatic cyc_t mk(input logic [29:0] i, input logic bb, input logic dd);
        cyc_t c;
        c.idx = i;
        c.b   = bb;
        c.d   = dd;
        return c;
    endfunction

    // One job: nominal timeline is index base+k in cycles 1..N, done at N+2
    // (cycle 1 for an empty job). Holding in cycle h repeats that cycle's
    // outputs hl more times. Garbage start/base/length is driven mid-job.
    task automatic run_job(input string tag, input logic [29:0] b, input int n,
                           input int h_in, input int hl);
        cyc_t        nq[$];
        cyc_t        eq[$];
        logic [SUM_W-1:0] exp_sum;
        logic        exp_ovf;
        longint      t;
        logic [29:0] a;
        int          dcy;
        int          h;
        exp_sum = '0;
        exp_ovf = 1'b0;
        for (int k = 0; k < n; k++) begin
            a = b + 30'(k);
            t = longint'($signed(exp_sum)) + longint'($signed(mem[a[3:0]]));
            if (t > 64'sd2147483647 || t < -64'sd2147483648) exp_ovf = 1'b1;
            exp_sum = exp_sum + mem[a[3:0]];
        end
        nq.push_back(mk(last_index, 1'b0, 1'b0));
        if (n == 0) begin
            nq.push_back(mk(last_index, 1'b0, 1'b1));
            dcy = 1;
        end else begin
            for (int c = 1; c <= n; c++) nq.push_back(mk(b + 30'(c - 1), 1'b1, 1'b0));
            nq.push_back(mk(b + 30'(n), 1'b1, 1'b0));
            nq.push_back(mk(b + 30'(n), 1'b0, 1'b1));
            dcy = n + 2;
            last_index = b + 30'(n);
        end
        nq.push_back(mk(last_index, 1'b0, 1'b0));
        h = (h_in > dcy) ? dcy : h_in;
        for (int c = 0; c < nq.size(); c++) begin
            eq.push_back(nq[c]);
            if (hl > 0 && c == h) for (int r = 0; r < hl; r++) eq.push_back(nq[c]);
        end

        @(negedge clk);
        start  = 1'b1;
        base   = b;
        length = LEN_W'(n);
        hold   = 1'b0;
        @(posedge clk);
        for (int c = 1; c < eq.size(); c++) begin
            @(negedge clk);
            n_cmp++;
            if (rom_index !== eq[c].idx) begin
                n_fail++;
                $display("FAIL %s cyc%0d rom_index got %h want %h", tag, c, rom_index, eq[c].idx);
            end
            n_cmp++;
            if (busy !== eq[c].b) begin
                n_fail++;
                $display("FAIL %s cyc%0d busy got %b want %b", tag, c, busy, eq[c].b);
            end
            n_cmp++;
            if (done !== eq[c].d) begin
                n_fail++;
                $display("FAIL %s cyc%0d done got %b want %b", tag, c, done, eq[c].d);
            end
            if (eq[c].d || c == eq.size() - 1) begin
                n_cmp++;
                if (sum !== exp_sum) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d sum got %h want %h", tag, c, sum, exp_sum);
                end
`ifdef ADDING_SEQ_OVERFLOW_EN
                n_cmp++;
                if (overflow !== exp_ovf) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d overflow got %b want %b", tag, c, overflow, exp_ovf);
                end
`endif
            end
            hold = (hl > 0 && c >= h && c < h + hl);
            if (c < eq.size() - 1) begin
                start  = 1'($urandom);
                base   = 30'($urandom);
                length = LEN_W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if (rom_index !== 30'd0 || busy !== 1'b0 || done !== 1'b0 || sum !== '0) begin
            n_fail++;
            $display("FAIL %s idx/busy/done/sum got %h/%b/%b/%h want 0/0/0/0",
                     tag, rom_index, busy, done, sum);
        end
`ifdef ADDING_SEQ_OVERFLOW_EN
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s overflow got %b want 0", tag, overflow);
        end
`endif
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("after_release");
        last_index = 30'd0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) mem[i] = SUM_W'(i + 1);
        run_job("basic", 30'd0, 4, 0, 0);
    endtask

    task automatic test_len_zero();
        run_job("len_zero", 30'h0ABCDEF, 0, 0, 0);
    endtask

    task automatic test_hold();
        run_job("hold", 30'd0, 4, 2, 3);
        run_job("hold_in_done", 30'd5, 3, 5, 2);
    endtask

    task automatic test_wrap();
        mem[14] = 32'd5;
        mem[15] = 32'd6;
        mem[0]  = 32'd7;
        run_job("wrap", 30'h3FFFFFFE, 3, 0, 0);
    endtask

    task automatic test_overflow();
        mem[0] = 32'h7FFFFFFF;
        mem[1] = 32'h00000001;
        run_job("ovf_set", 30'd0, 2, 0, 0);
        n_cmp++;
        if (sum !== 32'h80000000) begin
            n_fail++;
            $display("FAIL ovf_sum got %h want 80000000", sum);
        end
        mem[2] = 32'd3;
        mem[3] = 32'd4;
        run_job("ovf_clear", 30'd2, 2, 0, 0);
    endtask

    task automatic test_reset_mid_job();
        for (int i = 0; i < 16; i++) mem[i] = SUM_W'(i + 1);
        @(negedge clk);
        start  = 1'b1;
        base   = 30'd0;
        length = LEN_W'(4);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet cyc%0d done/busy got %b/%b want 0/0", c, done, busy);
            end
        end
        last_index = 30'd0;
        run_job("after_mid_reset", 30'd2, 4, 0, 0);
    endtask

    task automatic test_random();
        logic [29:0] b;
        int          n;
        int          hl;
        int          h;
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 16; i++) mem[i] = SUM_W'($urandom);
            if ($urandom_range(0, 2) == 0) b = 30'h3FFFFFF0 + 30'($urandom_range(0, 15));
            else b = 30'($urandom);
            n  = $urandom_range(0, 20);
            hl = $urandom_range(0, 3);
            h  = $urandom_range(1, (n == 0) ? 1 : n + 2);
            run_job($sformatf("rand%0d", j), b, n, h, hl);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) mem[i] = SUM_W'($urandom_range(0, 1000));
        run_job("b2b_a", 30'd3, 5, 0, 0);
        run_job("b2b_b", 30'd9, 1, 0, 0);
        run_job("b2b_c", 30'd1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_hold();
        test_wrap();
        test_overflow();
        test_reset_mid_job();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
